// File: rtl/router_pkg.sv
// Shared router types and default sizing.
// Used by the output-port arbiters and the router top.
package router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: the first set request at or after
// rr_ptr (wrapping) wins.
module rr_priority_pick
  import router_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    sum     = '0;
    j       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ))
        sum = sum - (IDX_W+1)'(NUM_REQ);
      j = sum[IDX_W-1:0];
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = j;
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Packet-locked round-robin arbiter feeding one output FIFO
// write port; the grant is held until the eop flit is written.
module rr_port_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_eop,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      fifo_full,
  output logic [NUM_REQ-1:0]        grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      fifo_winc,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      busy,
  output logic [15:0]               pkt_cnt
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;

  logic [NUM_REQ-1:0] pick_win;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               xfer;
  logic [DATA_W-1:0]  own_data;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign own_data = req_data[int'(grant_idx_q)*DATA_W +: DATA_W];
  assign xfer     = (state_q == LOCK) && req[grant_idx_q] && !fifo_full;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_cnt_d   = pkt_cnt_q;
    fifo_winc   = 1'b0;
    req_ack     = '0;
    fifo_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = LOCK;
          grant_d     = pick_win;
          grant_idx_d = pick_idx;
        end
      end
      LOCK: begin
        fifo_wdata = own_data;
        if (xfer) begin
          fifo_winc = 1'b1;
          req_ack   = grant_q;
          if (req_eop[grant_idx_q]) begin
            state_d   = IDLE;
            grant_d   = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (grant_idx_q == IDX_W'(NUM_REQ-1))
              rr_ptr_d = '0;
            else
              rr_ptr_d = grant_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == LOCK);
  assign pkt_cnt   = pkt_cnt_q;

endmodule
